maze_walker_ctrl: RTL and testbench
===================================

MAZE_WALKER_CTRL -- requirements
Module: maze_walker_ctrl

Interface
REQ-001 Parameters SHALL be:
- N = 16: maze side; cells (0,0) to (N-1,N-1).
- CW = $clog2(N): coordinate width.
- DEPTH = 256: path stack entries.
- SW = 10: step-counter width; MAX_STEPS = 2**SW-1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new solve.
- run  in  1  begin path replay.
- mem_rd_en  out  1  maze read request.
- mem_wr_en  out  1  visited-mark write.
- mem_x, mem_y  out  CW  cell address.
- mem_wdata  out  1  always 1.
- mem_valid  in  1  read data valid.
- mem_rdata  in  1  1 = wall or visited.
- move  out  2  replay direction.
- move_valid  out  1  move is valid.
- move_ready  in  1  consumer accepts move.
- cur_x, cur_y  out  CW  current position.
- path_len  out  $clog2(DEPTH+1)  stack occupancy.
- busy  out  1  solve or replay in progress.
- done  out  1  path found.
- fail  out  1  solve failed.
- err  out  2  failure cause.
- replay_done  out  1  one-cycle pulse at end of replay.
REQ-003 Direction encoding SHALL be 0=up(y-1), 1=right(x+1), 2=down(y+1), 3=left(x-1); err SHALL be 0=none, 1=no path, 2=stack overflow, 3=step timeout.

Function
REQ-004 FSM states SHALL be IDLE, MARK, REQ, WAIT, EVAL, BACK, SOLVED, FAILED, REPLAY.
REQ-005 In IDLE, SOLVED or FAILED, start=1 SHALL clear position to (0,0), sp, dir, step count, err, done and fail, then enter MARK; start SHALL be ignored in every other state.
REQ-006 MARK SHALL assert mem_wr_en for one cycle at (cur_x,cur_y); if the position is (N-1,N-1) the next state SHALL be SOLVED, otherwise REQ with dir=0.
REQ-007 REQ SHALL compute the neighbour in direction dir; an out-of-bounds neighbour SHALL be treated as blocked without a memory access, otherwise mem_rd_en SHALL pulse for one cycle and the FSM SHALL enter WAIT.
REQ-008 WAIT SHALL hold until mem_valid=1 with no timeout; the request address SHALL remain stable while waiting.
REQ-009 EVAL, neighbour free (mem_rdata=0): if sp==DEPTH then FAILED with err=2; otherwise push dir, move to the neighbour, increment the step count, and enter MARK.
REQ-010 EVAL, neighbour blocked: if dir<3 then dir+1 and REQ; otherwise enter BACK.
REQ-011 BACK, sp==0: enter FAILED with err=1.
REQ-012 BACK, sp>0: pop d, move in direction (d+2) mod 4, increment the step count, and set dir=d+1 (REQ) or, if d==3, remain in BACK; no MARK SHALL occur on a backtrack.
REQ-013 A step count reaching MAX_STEPS SHALL force FAILED with err=3 on the next cycle, with priority over every other transition.
REQ-014 done SHALL be held at 1 in SOLVED and fail SHALL be held at 1 in FAILED, both until the next start; busy SHALL be 1 in all states except IDLE, SOLVED and FAILED.
REQ-015 run=1 in SOLVED with sp>0 SHALL enter REPLAY; run in any other state, or with sp==0, SHALL be ignored; in SOLVED with sp==0, run SHALL not pulse replay_done.
REQ-016 REPLAY SHALL present stack entries in order from index 0 to sp-1 on move with move_valid=1; the index SHALL advance only when move_valid && move_ready, and move SHALL stay stable while stalled.
REQ-017 After the last accepted move, the FSM SHALL pulse replay_done for one cycle and return to SOLVED with the stack preserved, so replay can be repeated.
REQ-018 The block SHALL never clear maze memory; clearing it between solves is the system's responsibility.

Reset
REQ-019 rst=0 SHALL asynchronously force IDLE with all outputs at 0, cur=(0,0), sp=0 and err=0, including mid-solve, mid-wait and mid-replay; a mem_valid arriving after reset SHALL be ignored.

Structure
REQ-020 The state enum, direction codes, and err codes SHALL reside in the shared package maze_pkg.
REQ-021 The stack SHALL be a sub-module dir_stack: a DEPTH x 2-bit LIFO with push, pop, indexed read for replay, and sp, full and empty outputs.

Verification
REQ-022 The bench SHALL cover at least these scenarios:
- N=4, open maze, start -> moves right x3 then down x3; done=1, path_len=6; run with move_ready=1 -> moves 1,1,1,2,2,2 on consecutive cycles, then replay_done.
- N=4, walls at (1,0) and (0,1) -> FAILED, err=1, path_len=0.
- N=4, DEPTH=2, open maze -> FAILED with err=2 when the third push is attempted.
- SW=3, maze forcing backtracking -> FAILED with err=3 after 7 steps.
- Replay with move_ready toggling every other cycle -> each move held stable and none dropped or duplicated; mem_valid delayed 5 cycles -> identical path.
- rst=0 during WAIT and during REPLAY -> IDLE with all outputs 0; a following start solves normally.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze walker: FSM states, direction codes and
// failure codes, plus the direction-reversal helper used on backtrack.
package maze_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_MARK   = 4'd1,
        ST_REQ    = 4'd2,
        ST_WAIT   = 4'd3,
        ST_EVAL   = 4'd4,
        ST_BACK   = 4'd5,
        ST_SOLVED = 4'd6,
        ST_FAILED = 4'd7,
        ST_REPLAY = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NO_PATH  = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d + 2'd2;
    endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of 2-bit directions with an indexed read port so the stored path can be
// replayed from the bottom without disturbing the stack.
module dir_stack #(
    parameter int DEPTH = 256,
    parameter int PW    = $clog2(DEPTH + 1),
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    push_data,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_data,
    output logic [1:0]    top_data,
    output logic [PW-1:0] sp,
    output logic          full,
    output logic          empty
);

    logic [1:0]    mem_r [DEPTH];
    logic [PW-1:0] sp_r;
    logic [PW-1:0] sp_dec_s;

    assign sp_dec_s = sp_r - PW'(1'b1);
    assign rd_data  = mem_r[rd_idx];
    assign top_data = mem_r[sp_dec_s[IW-1:0]];
    assign sp       = sp_r;
    assign full     = (sp_r == PW'(DEPTH));
    assign empty    = (sp_r == '0);

    // Stack pointer: cleared on a new solve, guarded against over/underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_r <= '0;
        end else if (clr) begin
            sp_r <= '0;
        end else if (push && !full) begin
            sp_r <= sp_r + PW'(1'b1);
        end else if (pop && !empty) begin
            sp_r <= sp_dec_s;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Entry storage; slots at or above sp are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_r[sp_r[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/maze_walker_ctrl.sv
// Depth-first maze solver: marks visited cells in external memory, keeps the
// path on a direction stack, and replays the found path through a handshake.
module maze_walker_ctrl
    import maze_pkg::*;
#(
    parameter int N     = 16,
    parameter int CW    = $clog2(N),
    parameter int DEPTH = 256,
    parameter int SW    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         run,
    output logic                         mem_rd_en,
    output logic                         mem_wr_en,
    output logic [CW-1:0]                mem_x,
    output logic [CW-1:0]                mem_y,
    output logic                         mem_wdata,
    input  logic                         mem_valid,
    input  logic                         mem_rdata,
    output logic [1:0]                   move,
    output logic                         move_valid,
    input  logic                         move_ready,
    output logic [CW-1:0]                cur_x,
    output logic [CW-1:0]                cur_y,
    output logic [$clog2(DEPTH+1)-1:0]   path_len,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [1:0]                   err,
    output logic                         replay_done
);

    localparam int            PW        = $clog2(DEPTH + 1);
    localparam int            IW        = $clog2(DEPTH);
    localparam logic [SW-1:0] MAX_STEPS = {SW{1'b1}};
    localparam logic [CW-1:0] LAST      = CW'(N - 1);

    state_t        state_r;
    logic [CW-1:0] cur_x_r, cur_y_r, mem_x_r, mem_y_r;
    logic [1:0]    dir_r, err_r, move_r;
    logic [SW-1:0] step_r;
    logic [IW-1:0] ridx_r;
    logic          rdata_r, done_r, fail_r, busy_r, rd_en_r, wr_en_r;
    logic          move_valid_r, replay_done_r;

    logic [CW-1:0] nb_x_s, nb_y_s, bk_x_s, bk_y_s;
    logic [1:0]    top_s, rd_data_s, back_dir_s;
    logic [IW-1:0] rd_idx_s;
    logic [PW-1:0] sp_s;
    logic          nb_oob_s, full_s, empty_s, push_s, pop_s, start_ok_s;
    logic          timeout_s, last_move_s, at_goal_s;

    function automatic logic [CW-1:0] step_x(input logic [CW-1:0] x, input logic [1:0] d);
        case (d)
            DIR_RIGHT: step_x = x + CW'(1'b1);
            DIR_LEFT:  step_x = x - CW'(1'b1);
            default:   step_x = x;
        endcase
    endfunction

    function automatic logic [CW-1:0] step_y(input logic [CW-1:0] y, input logic [1:0] d);
        case (d)
            DIR_DOWN: step_y = y + CW'(1'b1);
            DIR_UP:   step_y = y - CW'(1'b1);
            default:  step_y = y;
        endcase
    endfunction

    function automatic logic is_oob(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input logic [1:0] d);
        case (d)
            DIR_UP:    is_oob = (y == '0);
            DIR_RIGHT: is_oob = (x == LAST);
            DIR_DOWN:  is_oob = (y == LAST);
            default:   is_oob = (x == '0);
        endcase
    endfunction

    // Neighbour under test, backtrack target and stack control strobes.
    always_comb begin
        nb_x_s      = step_x(cur_x_r, dir_r);
        nb_y_s      = step_y(cur_y_r, dir_r);
        nb_oob_s    = is_oob(cur_x_r, cur_y_r, dir_r);
        back_dir_s  = opposite_dir(top_s);
        bk_x_s      = step_x(cur_x_r, back_dir_s);
        bk_y_s      = step_y(cur_y_r, back_dir_s);
        at_goal_s   = (cur_x_r == LAST) && (cur_y_r == LAST);
        timeout_s   = (step_r == MAX_STEPS) &&
                      (state_r inside {ST_MARK, ST_REQ, ST_WAIT, ST_EVAL, ST_BACK});
        start_ok_s  = start && (state_r inside {ST_IDLE, ST_SOLVED, ST_FAILED});
        push_s      = (state_r == ST_EVAL) && !rdata_r && !full_s && !timeout_s;
        pop_s       = (state_r == ST_BACK) && !empty_s && !timeout_s;
        last_move_s = (PW'(ridx_r) == (sp_s - PW'(1'b1)));
        if (state_r == ST_REPLAY) begin
            rd_idx_s = ridx_r + IW'(1'b1);
        end else begin
            rd_idx_s = '0;
        end
    end

    dir_stack #(.DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (dir_r),
        .rd_idx    (rd_idx_s),
        .rd_data   (rd_data_s),
        .top_data  (top_s),
        .sp        (sp_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Walker FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cur_x_r       <= '0;
            cur_y_r       <= '0;
            mem_x_r       <= '0;
            mem_y_r       <= '0;
            dir_r         <= 2'd0;
            err_r         <= ERR_NONE;
            move_r        <= 2'd0;
            step_r        <= '0;
            ridx_r        <= '0;
            rdata_r       <= 1'b0;
            done_r        <= 1'b0;
            fail_r        <= 1'b0;
            busy_r        <= 1'b0;
            rd_en_r       <= 1'b0;
            wr_en_r       <= 1'b0;
            move_valid_r  <= 1'b0;
            replay_done_r <= 1'b0;
        end else begin
            rd_en_r       <= 1'b0;
            wr_en_r       <= 1'b0;
            replay_done_r <= 1'b0;
            if (timeout_s) begin
                state_r <= ST_FAILED;
                err_r   <= ERR_TIMEOUT;
                fail_r  <= 1'b1;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_SOLVED, ST_FAILED: begin
                        if (start_ok_s) begin
                            state_r <= ST_MARK;
                            cur_x_r <= '0;
                            cur_y_r <= '0;
                            mem_x_r <= '0;
                            mem_y_r <= '0;
                            wr_en_r <= 1'b1;
                            dir_r   <= DIR_UP;
                            step_r  <= '0;
                            err_r   <= ERR_NONE;
                            done_r  <= 1'b0;
                            fail_r  <= 1'b0;
                            busy_r  <= 1'b1;
                        end else if ((state_r == ST_SOLVED) && run && !empty_s) begin
                            state_r      <= ST_REPLAY;
                            ridx_r       <= '0;
                            move_r       <= rd_data_s;
                            move_valid_r <= 1'b1;
                            busy_r       <= 1'b1;
                        end
                    end
                    ST_MARK: begin
                        if (at_goal_s) begin
                            state_r <= ST_SOLVED;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_REQ;
                            dir_r   <= DIR_UP;
                        end
                    end
                    ST_REQ: begin
                        if (!nb_oob_s) begin
                            state_r <= ST_WAIT;
                            rd_en_r <= 1'b1;
                            mem_x_r <= nb_x_s;
                            mem_y_r <= nb_y_s;
                        end else if (dir_r != DIR_LEFT) begin
                            dir_r <= dir_r + 2'd1;
                        end else begin
                            state_r <= ST_BACK;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_valid) begin
                            rdata_r <= mem_rdata;
                            state_r <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        if (!rdata_r && full_s) begin
                            state_r <= ST_FAILED;
                            err_r   <= ERR_OVERFLOW;
                            fail_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (!rdata_r) begin
                            state_r <= ST_MARK;
                            cur_x_r <= nb_x_s;
                            cur_y_r <= nb_y_s;
                            mem_x_r <= nb_x_s;
                            mem_y_r <= nb_y_s;
                            wr_en_r <= 1'b1;
                            step_r  <= step_r + SW'(1'b1);
                        end else if (dir_r != DIR_LEFT) begin
                            state_r <= ST_REQ;
                            dir_r   <= dir_r + 2'd1;
                        end else begin
                            state_r <= ST_BACK;
                        end
                    end
                    ST_BACK: begin
                        if (empty_s) begin
                            state_r <= ST_FAILED;
                            err_r   <= ERR_NO_PATH;
                            fail_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            cur_x_r <= bk_x_s;
                            cur_y_r <= bk_y_s;
                            step_r  <= step_r + SW'(1'b1);
                            // A popped LEFT means every direction here is exhausted.
                            if (top_s != DIR_LEFT) begin
                                state_r <= ST_REQ;
                                dir_r   <= top_s + 2'd1;
                            end else begin
                                state_r <= ST_BACK;
                            end
                        end
                    end
                    ST_REPLAY: begin
                        if (move_valid_r && move_ready) begin
                            if (last_move_s) begin
                                state_r       <= ST_SOLVED;
                                move_valid_r  <= 1'b0;
                                replay_done_r <= 1'b1;
                                busy_r        <= 1'b0;
                            end else begin
                                ridx_r <= ridx_r + IW'(1'b1);
                                move_r <= rd_data_s;
                            end
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        move_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_rd_en   = rd_en_r;
    assign mem_wr_en   = wr_en_r;
    assign mem_x       = mem_x_r;
    assign mem_y       = mem_y_r;
    assign mem_wdata   = 1'b1;
    assign move        = move_r;
    assign move_valid  = move_valid_r;
    assign cur_x       = cur_x_r;
    assign cur_y       = cur_y_r;
    assign path_len    = sp_s;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fail        = fail_r;
    assign err         = err_r;
    assign replay_done = replay_done_r;

endmodule

// File: tb/tb_maze_walker_ctrl.sv
// Directed bench: three 4x4 walkers (default config, 2-deep stack, 3-bit step
// counter) sharing one clock, each with its own maze memory model.
module tb_maze_walker_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, start, run, move_ready, mclr;
    logic [2:0]       mem_valid, mem_rdata;
    logic [2:0]       mem_rd_en, mem_wr_en, mem_wdata, move_valid, busy, done, fail, replay_done;
    logic [2:0][1:0]  mem_x, mem_y, move, cur_x, cur_y, err;
    logic [8:0]       path_len0, path_len2;
    logic [1:0]       path_len1;
    logic [2:0][15:0] wall, visited;
    logic [2:0][2:0]  dly, cnt;
    logic [2:0]       pend = 3'b000;
    int               n_chk = 0;
    int               n_pass = 0;

    maze_walker_ctrl #(.N(4), .DEPTH(256), .SW(10)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .run(run[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_wr_en(mem_wr_en[0]), .mem_x(mem_x[0]), .mem_y(mem_y[0]),
        .mem_wdata(mem_wdata[0]), .mem_valid(mem_valid[0]), .mem_rdata(mem_rdata[0]),
        .move(move[0]), .move_valid(move_valid[0]), .move_ready(move_ready[0]),
        .cur_x(cur_x[0]), .cur_y(cur_y[0]), .path_len(path_len0), .busy(busy[0]),
        .done(done[0]), .fail(fail[0]), .err(err[0]), .replay_done(replay_done[0]));

    maze_walker_ctrl #(.N(4), .DEPTH(2), .SW(10)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .run(run[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_wr_en(mem_wr_en[1]), .mem_x(mem_x[1]), .mem_y(mem_y[1]),
        .mem_wdata(mem_wdata[1]), .mem_valid(mem_valid[1]), .mem_rdata(mem_rdata[1]),
        .move(move[1]), .move_valid(move_valid[1]), .move_ready(move_ready[1]),
        .cur_x(cur_x[1]), .cur_y(cur_y[1]), .path_len(path_len1), .busy(busy[1]),
        .done(done[1]), .fail(fail[1]), .err(err[1]), .replay_done(replay_done[1]));

    maze_walker_ctrl #(.N(4), .DEPTH(256), .SW(3)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .run(run[2]),
        .mem_rd_en(mem_rd_en[2]), .mem_wr_en(mem_wr_en[2]), .mem_x(mem_x[2]), .mem_y(mem_y[2]),
        .mem_wdata(mem_wdata[2]), .mem_valid(mem_valid[2]), .mem_rdata(mem_rdata[2]),
        .move(move[2]), .move_valid(move_valid[2]), .move_ready(move_ready[2]),
        .cur_x(cur_x[2]), .cur_y(cur_y[2]), .path_len(path_len2), .busy(busy[2]),
        .done(done[2]), .fail(fail[2]), .err(err[2]), .replay_done(replay_done[2]));

    // Maze memory: bench-set walls OR'd with DUT visited marks, answered dly cycles late.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mem_valid[i] <= 1'b0;
            if (mclr[i]) visited[i] <= 16'h0000;
            else if (mem_wr_en[i]) visited[i][{mem_y[i], mem_x[i]}] <= 1'b1;
            if (mem_rd_en[i]) begin
                pend[i] <= 1'b1;
                cnt[i]  <= dly[i];
            end else if (pend[i]) begin
                if (cnt[i] == 3'd0) begin
                    mem_valid[i] <= 1'b1;
                    mem_rdata[i] <= wall[i][{mem_y[i], mem_x[i]}] | visited[i][{mem_y[i], mem_x[i]}];
                    pend[i]      <= 1'b0;
                end else begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int i);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic clear_mem(input int i);
        mclr[i] = 1'b1;
        tick(1);
        mclr[i] = 1'b0;
    endtask

    task automatic wait_end(input int i, input string tag);
        int k = 0;
        while (!(done[i] || fail[i]) && k < 3000) begin
            tick(1);
            k++;
        end
        chk_eq(tag, 32'(k < 3000), 32'd1);
    endtask

    // Pulse run, then follow the replay: record accepted moves, check held moves while stalled.
    task automatic replay(input int i, input bit toggle, output logic [31:0] seq,
                          output int nacc, output int ncyc, output int nbad);
        int         k = 0;
        bit         ph = 1'b0;
        bit         stalled = 1'b0;
        logic [1:0] held = 2'd0;
        seq = 32'd0; nacc = 0; ncyc = 0; nbad = 0;
        move_ready[i] = 1'b0;
        run[i] = 1'b1;
        tick(1);
        run[i] = 1'b0;
        while (!replay_done[i] && k < 200) begin
            if (move_valid[i]) begin
                ncyc++;
                if (stalled && (move[i] !== held)) nbad++;
                move_ready[i] = toggle ? ph : 1'b1;
                ph = ~ph;
                if (move_ready[i]) begin
                    seq = (seq << 2) | 32'(move[i]);
                    nacc++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = move[i];
                end
            end else begin
                move_ready[i] = 1'b0;
            end
            tick(1);
            k++;
        end
        move_ready[i] = 1'b0;
    endtask

    function automatic logic [31:0] outs0();
        return 32'({mem_rd_en[0], mem_wr_en[0], mem_x[0], mem_y[0], move[0], move_valid[0],
                    cur_x[0], cur_y[0], path_len0, busy[0], done[0], fail[0], err[0],
                    replay_done[0]});
    endfunction

    initial begin
        logic [31:0] seq;
        int nacc, ncyc, nbad, k;
        rst = 3'b000; start = 3'b000; run = 3'b000; move_ready = 3'b000;
        mclr = 3'b111; wall = '0; dly = '0;
        tick(3);
        chk_eq("reset_outs", outs0(), 32'd0);
        chk_eq("reset_busy_all", 32'({busy, done, fail}), 32'd0);
        rst = 3'b111;
        tick(2);
        mclr = 3'b000;

        // Open 4x4 maze: right x3 then down x3.
        do_start(0);
        wait_end(0, "open_tmo");
        chk_eq("open_done_fail", 32'({done[0], fail[0]}), 32'd2);
        chk_eq("open_len", 32'(path_len0), 32'd6);
        chk_eq("open_pos", 32'({cur_x[0], cur_y[0]}), 32'hF);
        chk_eq("open_busy", 32'(busy[0]), 32'd0);
        replay(0, 1'b0, seq, nacc, ncyc, nbad);
        chk_eq("replay_moves", seq, 32'h56A);
        chk_eq("replay_cycles", 32'(ncyc), 32'd6);
        chk_eq("replay_done_hi", 32'(replay_done[0]), 32'd1);
        tick(1);
        chk_eq("replay_done_pulse", 32'({replay_done[0], busy[0], done[0]}), 32'd1);
        chk_eq("replay_len_kept", 32'(path_len0), 32'd6);

        // Repeat replay with a consumer that stalls every other cycle.
        replay(0, 1'b1, seq, nacc, ncyc, nbad);
        chk_eq("stall_moves", seq, 32'h56A);
        chk_eq("stall_accepted", 32'(nacc), 32'd6);
        chk_eq("stall_hold", 32'(nbad), 32'd0);
        chk_eq("stall_cycles", 32'(ncyc), 32'd12);

        // Same maze with slow memory.
        clear_mem(0);
        dly[0] = 3'd5;
        do_start(0);
        wait_end(0, "slow_tmo");
        chk_eq("slow_len", 32'(path_len0), 32'd6);
        replay(0, 1'b0, seq, nacc, ncyc, nbad);
        chk_eq("slow_moves", seq, 32'h56A);
        dly[0] = 3'd0;

        // Walls at (1,0) and (0,1): no path.
        clear_mem(0);
        wall[0] = 16'h0012;
        do_start(0);
        wait_end(0, "wall_tmo");
        chk_eq("wall_done_fail", 32'({done[0], fail[0]}), 32'd1);
        chk_eq("wall_err", 32'(err[0]), 32'd1);
        chk_eq("wall_len", 32'(path_len0), 32'd0);
        run[0] = 1'b1;
        tick(1);
        run[0] = 1'b0;
        tick(2);
        chk_eq("wall_run_ignored", 32'({busy[0], move_valid[0], replay_done[0]}), 32'd0);
        wall[0] = 16'h0000;

        // Two-entry stack overflows on the third push.
        do_start(1);
        wait_end(1, "ovf_tmo");
        chk_eq("ovf_fail", 32'(fail[1]), 32'd1);
        chk_eq("ovf_err", 32'(err[1]), 32'd2);
        chk_eq("ovf_len", 32'(path_len1), 32'd2);
        chk_eq("ovf_pos", 32'({cur_x[1], cur_y[1]}), 32'h8);

        // Walls at (1,1),(2,1),(3,1) force backtracking; 7th step times out at (0,1).
        wall[2] = 16'h00E0;
        do_start(2);
        wait_end(2, "tmo_tmo");
        chk_eq("tmo_fail", 32'({done[2], fail[2]}), 32'd1);
        chk_eq("tmo_err", 32'(err[2]), 32'd3);
        chk_eq("tmo_len", 32'(path_len2), 32'd1);
        chk_eq("tmo_pos", 32'({cur_x[2], cur_y[2]}), 32'h1);

        // Reset while waiting on memory, then solve again.
        clear_mem(0);
        dly[0] = 3'd5;
        do_start(0);
        k = 0;
        while (!mem_rd_en[0] && k < 100) begin
            tick(1);
            k++;
        end
        chk_eq("wait_req_seen", 32'(mem_rd_en[0]), 32'd1);
        tick(2);
        rst[0] = 1'b0;
        #1;
        chk_eq("wait_reset_outs", outs0(), 32'd0);
        tick(10);
        chk_eq("wait_reset_stale", outs0(), 32'd0);
        rst[0] = 1'b1;
        dly[0] = 3'd0;
        clear_mem(0);
        do_start(0);
        wait_end(0, "wait_resolve_tmo");
        chk_eq("wait_resolve", 32'({done[0], path_len0}), 32'h206);

        // Reset mid-replay with the consumer stalled, then solve and replay again.
        move_ready[0] = 1'b0;
        run[0] = 1'b1;
        tick(1);
        run[0] = 1'b0;
        tick(2);
        chk_eq("rep_held", 32'({move_valid[0], move[0]}), 32'h5);
        rst[0] = 1'b0;
        #1;
        chk_eq("rep_reset_outs", outs0(), 32'd0);
        tick(2);
        rst[0] = 1'b1;
        clear_mem(0);
        do_start(0);
        wait_end(0, "rep_resolve_tmo");
        replay(0, 1'b0, seq, nacc, ncyc, nbad);
        chk_eq("rep_resolve_moves", seq, 32'h56A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
